// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory port of the 64-bit MIPS core:
// FSM/owner encodings and default geometry.
package mips_mem_pkg;

  localparam int unsigned ADDR_W_DEF        = 32;
  localparam int unsigned DATA_W_DEF        = 64;
  localparam int unsigned MEM_LAT_DEF       = 2;
  localparam int unsigned DM_STREAK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_e;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes (fetch and data) plus the memory port, bundled for the arbiter.
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag; times fixed-latency memory reads.
module mem_lat_counter #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_count;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data
// access; data wins ties, a streak limit keeps fetch moving.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned MEM_LAT       = MEM_LAT_DEF,
  parameter int unsigned DM_STREAK_MAX = DM_STREAK_MAX_DEF
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned LAT_W    = cnt_w(MEM_LAT);
  localparam int unsigned STREAK_W = cnt_w(DM_STREAK_MAX + 32'd1);

  arb_state_e          r_state;
  owner_e              r_owner;
  logic [STREAK_W-1:0] r_streak;

  logic              r_if_ack;
  logic              r_dm_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;

  logic w_streak_full;
  logic w_grant_dm;
  logic w_grant_if;
  logic w_lat_load;
  logic w_lat_dec;
  logic w_lat_zero;

  // Data wins unless it has already taken DM_STREAK_MAX grants over a waiting fetch.
  assign w_streak_full = (r_streak == STREAK_W'(DM_STREAK_MAX));
  assign w_grant_dm    = bus.dm_req && !(bus.if_req && w_streak_full);
  assign w_grant_if    = bus.if_req && !w_grant_dm;

  // r_mem_we is still the latched write flag during ISSUE.
  assign w_lat_load = (r_state == ST_ISSUE) && !r_mem_we;
  assign w_lat_dec  = (r_state == ST_WAIT);

  mem_lat_counter #(
    .CNT_W (LAT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_lat_load),
    .i_load_val (LAT_W'(MEM_LAT - 32'd1)),
    .i_dec      (w_lat_dec),
    .o_zero_c   (w_lat_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_NONE;
      r_streak    <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_dm) begin
            r_state     <= ST_ISSUE;
            r_owner     <= OWN_DM;
            r_busy      <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.dm_we;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
            if (bus.if_req) begin
              r_streak <= w_streak_full ? r_streak : r_streak + STREAK_W'(1);
            end else begin
              r_streak <= '0;
            end
          end else if (w_grant_if) begin
            r_state    <= ST_ISSUE;
            r_owner    <= OWN_IF;
            r_busy     <= 1'b1;
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= bus.if_addr;
            r_streak   <= '0;
          end
        end
        ST_ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_mem_we) begin
            r_state  <= ST_RESP;
            r_dm_ack <= (r_owner == OWN_DM);
            r_if_ack <= (r_owner == OWN_IF);
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_lat_zero) begin
            r_state <= ST_RESP;
            if (r_owner == OWN_DM) begin
              r_dm_rdata <= bus.mem_rdata;
              r_dm_ack   <= 1'b1;
            end else begin
              r_if_rdata <= bus.mem_rdata;
              r_if_ack   <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1),
// directed stimulus with hand-computed ack/strobe cycles and data.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  typedef struct {
    int            cyc;
    bit            is_dm;
    logic [DW-1:0] rdata;
  } ack_exp_t;

  typedef struct {
    int            cyc;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ack_exp_t ack_q [2][$];
  mem_exp_t mem_q [2][$];

  logic          rst_s      [2];
  logic          if_req_s   [2];
  logic [AW-1:0] if_addr_s  [2];
  logic          dm_req_s   [2];
  logic          dm_we_s    [2];
  logic [AW-1:0] dm_addr_s  [2];
  logic [DW-1:0] dm_wdata_s [2];
  logic [1:0][8:0] nz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by reads.
  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    if (a == 32'h40) return 64'h0000_0000_DEAD_BEEF;
    return {~a, a} ^ 64'h5A5A_0000_0000_A5A5;
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g
    localparam int unsigned LAT = (d == 0) ? 2 : 1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [DW-1:0] pipe [LAT];
    int last_ack = -10;

    mem_port_arbiter #(
      .ADDR_W        (AW),
      .DATA_W        (DW),
      .MEM_LAT       (LAT),
      .DM_STREAK_MAX (4)
    ) dut (
      .clk (clk),
      .rst (rst_s[d]),
      .bus (bus)
    );

    assign bus.if_req    = if_req_s[d];
    assign bus.if_addr   = if_addr_s[d];
    assign bus.dm_req    = dm_req_s[d];
    assign bus.dm_we     = dm_we_s[d];
    assign bus.dm_addr   = dm_addr_s[d];
    assign bus.dm_wdata  = dm_wdata_s[d];
    assign bus.mem_rdata = pipe[LAT-1];
    assign nz[d] = {bus.if_ack, bus.dm_ack, bus.mem_en, bus.mem_we, bus.busy,
                    |bus.if_rdata, |bus.dm_rdata, |bus.mem_addr, |bus.mem_wdata};

    // Read data valid exactly LAT cycles after the strobe cycle, junk otherwise.
    always @(posedge clk) begin
      pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem_model(bus.mem_addr)
                                             : 64'hBAD0_BAD0_BAD0_BAD0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    always @(negedge clk) begin
      ack_exp_t      ea;
      mem_exp_t      em;
      logic [DW-1:0] act_rd;
      if (bus.if_ack || bus.dm_ack) begin
        checks++;
        if (ack_q[d].size() == 0) begin
          errors++;
          $display("FAIL dut%0d unexpected_ack cyc=%0d if_ack=%b dm_ack=%b",
                   d, cyc, bus.if_ack, bus.dm_ack);
        end else begin
          ea = ack_q[d].pop_front();
          act_rd = ea.is_dm ? bus.dm_rdata : bus.if_rdata;
          if (cyc != ea.cyc || bus.dm_ack != ea.is_dm || bus.if_ack == ea.is_dm ||
              !bus.busy || act_rd != ea.rdata || cyc == last_ack + 1) begin
            errors++;
            $display("FAIL dut%0d ack got cyc=%0d dm=%b if=%b busy=%b rdata=%h prev=%0d expected cyc=%0d dm=%b rdata=%h",
                     d, cyc, bus.dm_ack, bus.if_ack, bus.busy, act_rd, last_ack,
                     ea.cyc, ea.is_dm, ea.rdata);
          end
        end
        last_ack = cyc;
      end
      if (bus.mem_en) begin
        checks++;
        if (mem_q[d].size() == 0) begin
          errors++;
          $display("FAIL dut%0d unexpected_mem_en cyc=%0d addr=%h", d, cyc, bus.mem_addr);
        end else begin
          em = mem_q[d].pop_front();
          if (cyc != em.cyc || bus.mem_we != em.we || bus.mem_addr != em.addr ||
              (em.we && bus.mem_wdata != em.wdata)) begin
            errors++;
            $display("FAIL dut%0d mem_strobe got cyc=%0d we=%b addr=%h wdata=%h expected cyc=%0d we=%b addr=%h wdata=%h",
                     d, cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                     em.cyc, em.we, em.addr, em.wdata);
          end
        end
      end
      checks++;
      if (bus.mem_we && !bus.mem_en) begin
        errors++;
        $display("FAIL dut%0d mem_we_unqualified cyc=%0d mem_we=%b expected 0", d, cyc, bus.mem_we);
      end
    end
  end

  task automatic push_ack(input int d, input int c, input bit dm, input logic [DW-1:0] rd);
    ack_exp_t e;
    e.cyc = c; e.is_dm = dm; e.rdata = rd;
    ack_q[d].push_back(e);
  endtask

  task automatic push_mem(input int d, input int c, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd);
    mem_exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = wd;
    mem_q[d].push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input int d, input string nm);
    checks++;
    if (nz[d] != 9'd0) begin
      errors++;
      $display("FAIL %s dut%0d outputs_or=%b expected 000000000", nm, d, nz[d]);
    end
  endtask

  initial begin
    int c;
    logic [AW-1:0] a;
    bit dm;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; if_req_s[d] = 1'b0; if_addr_s[d] = '0;
      dm_req_s[d] = 1'b0; dm_we_s[d] = 1'b0; dm_addr_s[d] = '0; dm_wdata_s[d] = '0;
    end
    wait_neg(2);
    chk_zero(0, "reset_state");
    chk_zero(1, "reset_state");
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    wait_neg(1);

    // Single load, MEM_LAT=2.
    c = cyc;
    dm_req_s[0] = 1'b1; dm_we_s[0] = 1'b0; dm_addr_s[0] = 32'h40;
    push_mem(0, c + 1, 1'b0, 32'h40, '0);
    push_ack(0, c + 4, 1'b1, 64'h0000_0000_DEAD_BEEF);
    wait_neg(4); dm_req_s[0] = 1'b0;
    wait_neg(1);

    // Single store; dm_rdata keeps the previous load value.
    c = cyc;
    dm_req_s[0] = 1'b1; dm_we_s[0] = 1'b1; dm_addr_s[0] = 32'h80; dm_wdata_s[0] = 64'h1234;
    push_mem(0, c + 1, 1'b1, 32'h80, 64'h1234);
    push_ack(0, c + 2, 1'b1, 64'h0000_0000_DEAD_BEEF);
    wait_neg(2); dm_req_s[0] = 1'b0; dm_we_s[0] = 1'b0;
    wait_neg(2);

    // Both requesters held: DM,DM,DM,DM,IF repeating, one load every 5 cycles.
    c = cyc;
    if_req_s[0] = 1'b1; if_addr_s[0] = 32'h100;
    dm_req_s[0] = 1'b1; dm_addr_s[0] = 32'h200;
    for (int k = 0; k < 10; k++) begin
      dm = ((k % 5) != 4);
      a  = dm ? 32'h200 : 32'h100;
      push_mem(0, c + 1 + 5 * k, 1'b0, a, '0);
      push_ack(0, c + 4 + 5 * k, dm, mem_model(a));
    end
    wait_neg(49); if_req_s[0] = 1'b0; dm_req_s[0] = 1'b0;
    wait_neg(2);

    // Reset during WAIT of a load, then reissue.
    c = cyc;
    dm_req_s[0] = 1'b1; dm_we_s[0] = 1'b0; dm_addr_s[0] = 32'h48;
    push_mem(0, c + 1, 1'b0, 32'h48, '0);
    wait_neg(2); rst_s[0] = 1'b1; dm_req_s[0] = 1'b0;
    wait_neg(1); chk_zero(0, "reset_in_wait"); rst_s[0] = 1'b0;
    wait_neg(1);
    c = cyc;
    dm_req_s[0] = 1'b1;
    push_mem(0, c + 1, 1'b0, 32'h48, '0);
    push_ack(0, c + 4, 1'b1, mem_model(32'h48));
    wait_neg(4); dm_req_s[0] = 1'b0;
    wait_neg(1);

    // Fetch only, MEM_LAT=1: acks every 4 cycles.
    c = cyc;
    if_req_s[1] = 1'b1; if_addr_s[1] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      a = 32'(4 * k);
      push_mem(1, c + 1 + 4 * k, 1'b0, a, '0);
      push_ack(1, c + 3 + 4 * k, 1'b0, mem_model(a));
    end
    wait_neg(3); if_addr_s[1] = 32'h4;
    wait_neg(4); if_addr_s[1] = 32'h8;
    wait_neg(4); if_req_s[1] = 1'b0;
    wait_neg(1);

    // Store then load with dm_req held, MEM_LAT=1.
    c = cyc;
    dm_req_s[1] = 1'b1; dm_we_s[1] = 1'b1; dm_addr_s[1] = 32'h90; dm_wdata_s[1] = 64'hCAFE;
    push_mem(1, c + 1, 1'b1, 32'h90, 64'hCAFE);
    push_ack(1, c + 2, 1'b1, '0);
    push_mem(1, c + 4, 1'b0, 32'h98, '0);
    push_ack(1, c + 6, 1'b1, mem_model(32'h98));
    wait_neg(2); dm_we_s[1] = 1'b0; dm_addr_s[1] = 32'h98;
    wait_neg(4); dm_req_s[1] = 1'b0;
    wait_neg(5);

    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ack_q[d].size() != 0 || mem_q[d].size() != 0) begin
        errors++;
        $display("FAIL dut%0d missing_events acks_left=%0d strobes_left=%0d expected 0",
                 d, ack_q[d].size(), mem_q[d].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port unified memory between the instruction-fetch stage and the data-memory stage (lw/sw) of the 64-bit MIPS CPU. Each requester runs a req/ack handshake; the arbiter grants one transaction at a time, drives the memory port, waits out the fixed read latency, and returns read data with a one-cycle ack. Data requests take priority, and a streak limit guarantees fetch forward progress.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 64, data width
- `MEM_LAT`, 2, memory read latency in cycles (≥1)
- `DM_STREAK_MAX`, 4, maximum consecutive data grants while a fetch is pending (≥1)

- `clk`  in  1  clock; everything on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_ack`  out  1  one-cycle pulse; `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched word
- `dm_req`  in  1  data request, held until `dm_ack`
- `dm_we`  in  1  1 = store (sw), 0 = load (lw)
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_ack`  out  1  one-cycle pulse; `dm_rdata` valid for loads
- `dm_rdata`  out  DATA_W  load data
- `mem_en`  out  1  memory access strobe, one cycle per transaction
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  valid MEM_LAT cycles after the `mem_en` cycle
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- All outputs reset to 0. FSM resets to IDLE, owner to none, streak counter to 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any request is present, latch the owner and the address/data/we, then go to ISSUE.
  - ISSUE: drive `mem_en`=1 for exactly one cycle. A write goes to RESP. A read loads the latency counter with MEM_LAT−1 and goes to WAIT.
  - WAIT: count down. At 0, capture `mem_rdata` into the owner's rdata register and go to RESP. With MEM_LAT=1, WAIT lasts one cycle.
  - RESP: pulse the owner's ack for one cycle, then go to IDLE.
- Grant rule in IDLE:
  - Only `dm_req` present: grant data.
  - Only `if_req` present: grant fetch.
  - Both present: grant data unless streak = DM_STREAK_MAX, in which case grant fetch.
- Streak counter:
  - Increments on each data grant made while `if_req` is high.
  - Clears on any fetch grant, or on a data grant made while `if_req` is low.
  - Saturates at DM_STREAK_MAX.
- Fetch transactions are always reads. `mem_we` is 0 for them.
- `mem_addr`/`mem_wdata` hold their last value outside ISSUE. `mem_we` is 0 outside ISSUE.
- `if_rdata`/`dm_rdata` hold their value until the next load completes for that port.
- A request that drops before its ack is a protocol violation. The arbiter does not check it; the latched transaction still completes.
- Reset mid-transaction:
  - FSM goes to IDLE immediately and all outputs go to 0.
  - The in-flight transaction is discarded with no ack. A store already strobed may have written memory.

## Timing
- Grant decided in IDLE cycle t. ISSUE is cycle t+1.
- Load: data captured at t+1+MEM_LAT, ack at t+2+MEM_LAT, total latency MEM_LAT+2 cycles from IDLE to ack.
- Store: ack at t+2.
- The requester may present a new request in the cycle after ack. It is sampled in the next IDLE cycle.
- Minimum period: loads MEM_LAT+3 cycles per transaction, stores 3 cycles.
- Both requests arriving in the same IDLE cycle are resolved by the grant rule. Neither is lost; the loser stays pending.
- `busy` is registered with the state.

## Structure
- Shared package `mips_mem_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP)
  - the owner encoding (NONE/IF/DM)
  - default values of ADDR_W, DATA_W, MEM_LAT and DM_STREAK_MAX
- One natural sub-module: `mem_lat_counter`, a loadable down-counter with a zero flag, reused by future peripheral ports.

## Test plan
- Single load, MEM_LAT=2: `dm_req`=1, `dm_we`=0, `dm_addr`=0x40, memory returns 0xDEAD_BEEF → `mem_en` high one cycle with addr 0x40; `dm_ack` 4 cycles after the grant cycle with `dm_rdata`=0xDEAD_BEEF.
- Single store: `dm_we`=1, addr 0x80, wdata 0x1234 → `mem_en`=`mem_we`=1 one cycle with those values; `dm_ack` 2 cycles after the grant; `if_ack` never asserts.
- Simultaneous `if_req`+`dm_req` held continuously, DM_STREAK_MAX=4 → grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF…; no back-to-back acks.
- Fetch only, `if_addr`=0x0, 0x4, 0x8 back-to-back, MEM_LAT=1 → three `if_ack`s spaced 4 cycles apart with correct rdata.
- Reset in WAIT of a load: `rst` pulsed → next edge outputs all 0, state IDLE, no `dm_ack`; a reissued load then completes normally.
- MEM_LAT=1 load after store with `dm_req` held: store ack, then the load is granted in the following IDLE cycle and acks 3 cycles later.
